// File: rtl/regfile_wport_arbiter_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_wport_arbiter_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [31:0] word_t;

  // One register-file write: valid strobe, destination GPR and value.
  typedef struct packed {
    logic       valid;
    creg_addr_t id;
    word_t      data;
  } rf_wreq_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_PIPE,
    GRANT_FIFO,
    GRANT_FORCE
  } grant_src_e;

  localparam int ARB_DEPTH      = 2;
  localparam int ARB_STARVE_MAX = 4;

  // A write to r0 is architecturally a no-op, so only valid non-r0 writes count.
  function automatic logic isEffective(rf_wreq_t req);
    return req.valid && (req.id != '0);
  endfunction

endpackage

// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of writeback, late-result, register-file and hazard-unit signals
// seen by the write-port arbiter.
interface regfile_wport_arbiter_if #(
  parameter int DEPTH = regfile_wport_arbiter_pkg::ARB_DEPTH
);
  import regfile_wport_arbiter_pkg::*;

  rf_wreq_t             pipe_req;
  rf_wreq_t             late_req;
  logic                 late_ready;
  logic                 stall_wb;
  rf_wreq_t             rf_write;
  creg_addr_t           chk_id;
  logic                 chk_hit;
  logic [$clog2(DEPTH):0] fifo_count;

  // Arbiter side.
  modport slave (
    input  pipe_req, late_req, chk_id,
    output late_ready, stall_wb, rf_write, chk_hit, fifo_count
  );

  // Surrounding pipeline / producers / hazard unit side.
  modport master (
    output pipe_req, late_req, chk_id,
    input  late_ready, stall_wb, rf_write, chk_hit, fifo_count
  );

endinterface

// File: rtl/regfile_wport_arbiter_wb_late_fifo.sv
// In-order buffer for late results waiting for a free write-port slot.
// Exposes per-entry valid/id so the hazard unit can see queued destinations.
module wb_late_fifo
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  rf_wreq_t                 pushData_i,
  input  logic                     pop_i,
  output rf_wreq_t                 head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DEPTH-1:0]         entryValid_o,
  output creg_addr_t [DEPTH-1:0]   entryId_o
);

  localparam int PW = $clog2(DEPTH);

  rf_wreq_t         mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Entry storage; contents need no reset because valid_q qualifies them.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= pushData_i;
    end
  end

  // Occupancy flags: the popped slot frees before the pushed slot fills.
  always_comb begin
    valid_d = valid_q;
    if (pop_i) begin
      valid_d[rdPtr_q] = 1'b0;
    end
    if (push_i) begin
      valid_d[wrPtr_q] = 1'b1;
    end
  end

  // Pointer, count and flag registers; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (!push_i && pop_i) begin
        count_q <= count_q - 1'b1;
      end
      valid_q <= valid_d;
    end
  end

  // Destination ids of every slot for the hazard compare.
  always_comb begin
    entryId_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entryId_o[i] = mem_q[i].id;
    end
  end

  assign head_o       = mem_q[rdPtr_q];
  assign count_o      = count_q;
  assign entryValid_o = valid_q;

endmodule

// File: rtl/regfile_wport_arbiter.sv
// Single register-file write port shared by in-order writeback and late
// results (uncached loads, divider). Late results queue in a small FIFO and
// fill idle slots; a starvation counter stalls writeback to force a drain.
module regfile_wport_arbiter
  import regfile_wport_arbiter_pkg::*;
#(
  parameter int DEPTH      = ARB_DEPTH,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input logic                    clk,
  input logic                    reset,
  regfile_wport_arbiter_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  rf_wreq_t               fifoHead;
  logic [CW-1:0]          fifoCount;
  logic [CW-1:0]          countNext;
  logic [DEPTH-1:0]       entryValid;
  creg_addr_t [DEPTH-1:0] entryId;
  logic                   fifoPush;
  logic                   fifoPop;
  logic                   fifoEmpty;
  logic                   forceDrain;
  logic                   chkHit;
  logic [SW-1:0]          starve_q;
  logic [SW-1:0]          starve_d;
  grant_src_e             grantSrc;

  wb_late_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (fifoPush),
    .pushData_i   (bus.late_req),
    .pop_i        (fifoPop),
    .head_o       (fifoHead),
    .count_o      (fifoCount),
    .entryValid_o (entryValid),
    .entryId_o    (entryId)
  );

  assign fifoEmpty  = (fifoCount == '0);
  assign forceDrain = !fifoEmpty && (starve_q == STARVE_LIMIT);

  // No bypass when full: a pop this cycle only frees space for next cycle.
  assign bus.late_ready = !reset && (fifoCount < FULL_COUNT);

  // r0 late results complete the handshake but are never stored.
  assign fifoPush = bus.late_ready && bus.late_req.valid && (bus.late_req.id != '0);

  // Built only from registered state so the hazard unit sees no loop via pipe_req.
  assign bus.stall_wb = !reset && forceDrain;

  // Pick the port owner: forced drain, then writeback, then opportunistic drain.
  always_comb begin
    grantSrc = GRANT_NONE;
    if (reset) begin
      grantSrc = GRANT_NONE;
    end else if (forceDrain) begin
      grantSrc = GRANT_FORCE;
    end else if (isEffective(bus.pipe_req)) begin
      grantSrc = GRANT_PIPE;
    end else if (!fifoEmpty) begin
      grantSrc = GRANT_FIFO;
    end
  end

  // Steer the chosen request onto the write port and pop the FIFO when it wins.
  always_comb begin
    bus.rf_write = '0;
    fifoPop      = 1'b0;
    unique case (grantSrc)
      GRANT_PIPE: begin
        bus.rf_write = bus.pipe_req;
      end
      GRANT_FIFO, GRANT_FORCE: begin
        bus.rf_write = fifoHead;
        fifoPop      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Starvation count: zero once drained or emptied, else climbs to the limit.
  always_comb begin
    countNext = fifoCount;
    if (fifoPush && !fifoPop) begin
      countNext = fifoCount + 1'b1;
    end else if (!fifoPush && fifoPop) begin
      countNext = fifoCount - 1'b1;
    end
    starve_d = starve_q;
    if (fifoPop || (countNext == '0)) begin
      starve_d = '0;
    end else if (starve_q != STARVE_LIMIT) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Any queued entry (including one leaving this cycle) targeting chk_id is a hit.
  always_comb begin
    chkHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && (entryId[i] == bus.chk_id)) begin
        chkHit = 1'b1;
      end
    end
  end

  assign bus.chk_hit    = chkHit && !reset && (bus.chk_id != '0);
  assign bus.fifo_count = reset ? '0 : fifoCount;

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Self-checking bench for the register-file write-port arbiter: directed
// scenarios plus a randomized run against a queue-based reference model.
module tb_regfile_wport_arbiter;
  import regfile_wport_arbiter_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;
  localparam int CW         = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  int   testsRun    = 0;
  int   testsFailed = 0;

  localparam rf_wreq_t IDLE = '0;

  regfile_wport_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_wport_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic rf_wreq_t mk(logic v, creg_addr_t id, word_t d);
    rf_wreq_t r;
    r.valid = v;
    r.id    = id;
    r.data  = d;
    return r;
  endfunction

  // One cycle: drive inputs on the falling edge, let combinational outputs settle.
  task automatic applyStimulus(input logic rst, input rf_wreq_t pipe,
                               input rf_wreq_t late, input creg_addr_t chk);
    @(negedge clk);
    reset        = rst;
    bus.pipe_req = pipe;
    bus.late_req = late;
    bus.chk_id   = chk;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, mk(1, 3, 32'h3), mk(1, 5, 32'h5), 5'd5);
    testsRun++; if (bus.late_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_ready got=%0b exp=0", bus.late_ready); end
    testsRun++; if (bus.stall_wb !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_stall got=%0b exp=0", bus.stall_wb); end
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_wvalid got=%0b exp=0", bus.rf_write.valid); end
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_hit got=%0b exp=0", bus.chk_hit); end
    testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL rst_count got=%0d exp=0", bus.fifo_count); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd0);
    testsRun++; if (bus.late_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL post_rst_ready got=%0b exp=1", bus.late_ready); end
    testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL post_rst_count got=%0d exp=0", bus.fifo_count); end
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL post_rst_wvalid got=%0b exp=0", bus.rf_write.valid); end
  endtask

  task automatic test_idle_late();
    rf_wreq_t r5 = mk(1, 5, 32'hDEAD);
    applyStimulus(1'b0, IDLE, r5, 5'd0);
    testsRun++; if (bus.late_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL idle_ready got=%0b exp=1", bus.late_ready); end
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_t0_wvalid got=%0b exp=0", bus.rf_write.valid); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd0);
    testsRun++; if (bus.rf_write !== r5) begin testsFailed++; $display("[TB] FAIL idle_t1_write got=%h exp=%h", bus.rf_write, r5); end
    testsRun++; if (bus.fifo_count !== CW'(1)) begin testsFailed++; $display("[TB] FAIL idle_t1_count got=%0d exp=1", bus.fifo_count); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd0);
    testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL idle_t2_count got=%0d exp=0", bus.fifo_count); end
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_t2_wvalid got=%0b exp=0", bus.rf_write.valid); end
  endtask

  task automatic test_starve_force();
    rf_wreq_t p  = mk(1, 3, 32'hA0A0_0003);
    rf_wreq_t r7 = mk(1, 7, 32'h7777_0007);
    for (int t = 0; t <= 5; t++) begin
      applyStimulus(1'b0, p, (t == 0) ? r7 : IDLE, 5'd0);
      if (t == 4) begin
        testsRun++; if (bus.stall_wb !== 1'b1) begin testsFailed++; $display("[TB] FAIL starve_t4_stall got=%0b exp=1", bus.stall_wb); end
        testsRun++; if (bus.rf_write !== r7) begin testsFailed++; $display("[TB] FAIL starve_t4_write got=%h exp=%h", bus.rf_write, r7); end
      end else begin
        testsRun++; if (bus.stall_wb !== 1'b0) begin testsFailed++; $display("[TB] FAIL starve_t%0d_stall got=%0b exp=0", t, bus.stall_wb); end
        testsRun++; if (bus.rf_write !== p) begin testsFailed++; $display("[TB] FAIL starve_t%0d_write got=%h exp=%h", t, bus.rf_write, p); end
      end
      if (t == 5) begin
        testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL starve_t5_count got=%0d exp=0", bus.fifo_count); end
      end
    end
  endtask

  task automatic test_fill_backpressure();
    rf_wreq_t p = mk(1, 3, 32'h3333_3333);
    rf_wreq_t expOrder [3];
    rf_wreq_t seen [$];
    bit cAccepted = 1'b0;
    bit sawForce  = 1'b0;
    int heldCycles = 0;
    expOrder[0] = mk(1, 10, 32'hAAAA_000A);
    expOrder[1] = mk(1, 11, 32'hBBBB_000B);
    expOrder[2] = mk(1, 12, 32'hCCCC_000C);
    seen.delete();
    applyStimulus(1'b0, p, expOrder[0], 5'd0);
    applyStimulus(1'b0, p, expOrder[1], 5'd0);
    for (int cyc = 0; cyc < 40 && seen.size() < 3; cyc++) begin
      applyStimulus(1'b0, p, cAccepted ? IDLE : expOrder[2], 5'd0);
      if (cyc == 0) begin
        testsRun++; if (bus.late_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_ready got=%0b exp=0", bus.late_ready); end
        testsRun++; if (bus.fifo_count !== CW'(2)) begin testsFailed++; $display("[TB] FAIL fill_count got=%0d exp=2", bus.fifo_count); end
      end
      if (bus.stall_wb === 1'b1 && !sawForce) begin
        sawForce = 1'b1;
        testsRun++; if (bus.late_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL fill_nobypass got=%0b exp=0", bus.late_ready); end
      end
      if (bus.rf_write.valid === 1'b1 && bus.rf_write.id !== 5'd3) seen.push_back(bus.rf_write);
      if (!cAccepted) begin
        if (bus.late_ready === 1'b1) cAccepted = 1'b1;
        else heldCycles++;
      end
    end
    testsRun++; if (seen.size() != 3) begin testsFailed++; $display("[TB] FAIL fill_drained got=%0d exp=3", seen.size()); end
    testsRun++; if (heldCycles != 3) begin testsFailed++; $display("[TB] FAIL fill_held got=%0d exp=3", heldCycles); end
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) begin
        testsRun++; if (seen[i] !== expOrder[i]) begin testsFailed++; $display("[TB] FAIL fill_order%0d got=%h exp=%h", i, seen[i], expOrder[i]); end
      end
    end
    applyStimulus(1'b0, IDLE, IDLE, 5'd0);
  endtask

  task automatic test_pipe_id0();
    rf_wreq_t r9 = mk(1, 9, 32'h9000_900D);
    applyStimulus(1'b0, mk(1, 3, 32'h3), r9, 5'd0);
    applyStimulus(1'b0, mk(1, 0, 32'h1234), IDLE, 5'd0);
    testsRun++; if (bus.rf_write !== r9) begin testsFailed++; $display("[TB] FAIL id0_write got=%h exp=%h", bus.rf_write, r9); end
    testsRun++; if (bus.stall_wb !== 1'b0) begin testsFailed++; $display("[TB] FAIL id0_stall got=%0b exp=0", bus.stall_wb); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd0);
    testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL id0_count got=%0d exp=0", bus.fifo_count); end
  endtask

  task automatic test_chk_hit();
    rf_wreq_t p  = mk(1, 3, 32'h3);
    rf_wreq_t r9 = mk(1, 9, 32'h0000_0099);
    applyStimulus(1'b0, p, r9, 5'd9);
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL chk_t0 got=%0b exp=0", bus.chk_hit); end
    applyStimulus(1'b0, p, IDLE, 5'd0);
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL chk_zero got=%0b exp=0", bus.chk_hit); end
    applyStimulus(1'b0, p, IDLE, 5'd9);
    testsRun++; if (bus.chk_hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL chk_queued got=%0b exp=1", bus.chk_hit); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd9);
    testsRun++; if (bus.chk_hit !== 1'b1) begin testsFailed++; $display("[TB] FAIL chk_popping got=%0b exp=1", bus.chk_hit); end
    testsRun++; if (bus.rf_write !== r9) begin testsFailed++; $display("[TB] FAIL chk_write got=%h exp=%h", bus.rf_write, r9); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd9);
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL chk_after got=%0b exp=0", bus.chk_hit); end
  endtask

  task automatic test_reset_mid();
    rf_wreq_t p = mk(1, 3, 32'h3);
    applyStimulus(1'b0, p, mk(1, 20, 32'h20), 5'd0);
    applyStimulus(1'b0, p, mk(1, 21, 32'h21), 5'd0);
    applyStimulus(1'b0, p, IDLE, 5'd0);
    testsRun++; if (bus.fifo_count !== CW'(2)) begin testsFailed++; $display("[TB] FAIL rmid_setup got=%0d exp=2", bus.fifo_count); end
    applyStimulus(1'b1, p, mk(1, 22, 32'h22), 5'd20);
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_wvalid got=%0b exp=0", bus.rf_write.valid); end
    testsRun++; if (bus.late_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_ready got=%0b exp=0", bus.late_ready); end
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_hit got=%0b exp=0", bus.chk_hit); end
    applyStimulus(1'b0, IDLE, IDLE, 5'd20);
    testsRun++; if (bus.fifo_count !== CW'(0)) begin testsFailed++; $display("[TB] FAIL rmid_count got=%0d exp=0", bus.fifo_count); end
    testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_after_wvalid got=%0b exp=0", bus.rf_write.valid); end
    testsRun++; if (bus.stall_wb !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_stall got=%0b exp=0", bus.stall_wb); end
    testsRun++; if (bus.late_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL rmid_after_ready got=%0b exp=1", bus.late_ready); end
    testsRun++; if (bus.chk_hit !== 1'b0) begin testsFailed++; $display("[TB] FAIL rmid_after_hit got=%0b exp=0", bus.chk_hit); end
  endtask

  // Random traffic against a model holding pending late results in a queue.
  task automatic test_random();
    rf_wreq_t   q [$];
    int         starve;
    logic       rst;
    int         busyPct;
    rf_wreq_t   pipe;
    rf_wreq_t   late;
    creg_addr_t chk;
    logic       expReady;
    logic       expStall;
    logic       expHit;
    logic       doPop;
    rf_wreq_t   expWrite;
    logic [CW-1:0] expCount;
    applyStimulus(1'b1, IDLE, IDLE, 5'd0);
    q.delete();
    starve = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst     = ($urandom_range(0, 99) < 2);
      busyPct = (((cyc / 60) % 2) == 0) ? 90 : 35;
      pipe    = mk($urandom_range(0, 99) < busyPct, 5'($urandom_range(0, 7)), $urandom);
      late    = mk($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
      chk     = 5'($urandom_range(0, 7));
      applyStimulus(rst, pipe, late, chk);

      expReady = !rst && (q.size() < DEPTH);
      expStall = !rst && (q.size() != 0) && (starve == STARVE_MAX);
      expWrite = IDLE;
      doPop    = 1'b0;
      if (!rst) begin
        if (expStall) begin
          expWrite = q[0];
          doPop    = 1'b1;
        end else if (pipe.valid && pipe.id != 0) begin
          expWrite = pipe;
        end else if (q.size() != 0) begin
          expWrite = q[0];
          doPop    = 1'b1;
        end
      end
      expHit = 1'b0;
      if (!rst && chk != 0) begin
        foreach (q[i]) if (q[i].id == chk) expHit = 1'b1;
      end
      expCount = rst ? CW'(0) : CW'(q.size());

      testsRun++; if (bus.late_ready !== expReady) begin testsFailed++; $display("[TB] FAIL rnd%0d_ready got=%0b exp=%0b", cyc, bus.late_ready, expReady); end
      testsRun++; if (bus.stall_wb !== expStall) begin testsFailed++; $display("[TB] FAIL rnd%0d_stall got=%0b exp=%0b", cyc, bus.stall_wb, expStall); end
      testsRun++; if (bus.chk_hit !== expHit) begin testsFailed++; $display("[TB] FAIL rnd%0d_hit got=%0b exp=%0b", cyc, bus.chk_hit, expHit); end
      testsRun++; if (bus.fifo_count !== expCount) begin testsFailed++; $display("[TB] FAIL rnd%0d_count got=%0d exp=%0d", cyc, bus.fifo_count, expCount); end
      if (expWrite.valid) begin
        testsRun++; if (bus.rf_write !== expWrite) begin testsFailed++; $display("[TB] FAIL rnd%0d_write got=%h exp=%h", cyc, bus.rf_write, expWrite); end
      end else begin
        testsRun++; if (bus.rf_write.valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL rnd%0d_wvalid got=%0b exp=0", cyc, bus.rf_write.valid); end
      end

      if (rst) begin
        q.delete();
        starve = 0;
      end else begin
        if (doPop) void'(q.pop_front());
        if (late.valid && expReady && late.id != 0) q.push_back(late);
        if (doPop || q.size() == 0) starve = 0;
        else if (starve < STARVE_MAX) starve++;
      end
    end
  endtask

  // Test sequence.
  initial begin
    reset        = 1'b1;
    bus.pipe_req = IDLE;
    bus.late_req = IDLE;
    bus.chk_id   = '0;
    test_reset();
    test_idle_late();
    test_starve_force();
    test_fill_backpressure();
    test_pipe_id0();
    test_chk_hit();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
